regfile_bank: RTL and testbench

//  Parametrised successor of the fixed 8x16 register file: DEPTH x WIDTH general registers plus NB operand buffers.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_rd_port.sv | 37 +++
 rtl/regfile_bank.sv | 142 ++++++++++++++
 tb/tb_regfile_bank.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register bank.
package regfile_pkg;

  // Soft-clear sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sclr_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_NB    = 1;

  // Number of registered read ports (A, B)
  localparam int NRD = 2;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address decode, write-first forward, output flop.
// An out-of-range address decodes to no register and reads 0.
import regfile_pkg::*;

module regfile_rd_port #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                         CLK,
  input  logic                         CLR,
  input  logic [AW-1:0]                addr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
  input  logic                         wr_ok,
  input  logic [AW-1:0]                waddr,
  input  logic [WIDTH-1:0]             s_bus,
  output logic [WIDTH-1:0]             data
);

  logic [WIDTH-1:0] rd_nxt;

  // Decode the stored word, then let an accepted same-edge write override it
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) rd_nxt = regs[i];
    end
    if (wr_ok && (waddr == addr)) rd_nxt = s_bus;
  end

  // Output register, one cycle of read latency
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) data <= '0;
    else      data <= rd_nxt;
  end

endmodule

// File: rtl/regfile_bank.sv
// DEPTH x WIDTH register bank with NB operand buffers, two registered read
// ports with write-first forwarding, and a sequenced soft-clear sweep.
// Optional build macro REGFILE_R0_ZERO_EN: register 0 is hardwired to zero,
// writes to it are silently discarded and it is never forwarded.
import regfile_pkg::*;

module regfile_bank #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NB    = DEF_NB,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     s_bus,
  input  logic [NB-1:0]        sb,
  input  logic [AW-1:0]        ra_addr,
  input  logic [AW-1:0]        rb_addr,
  output logic [WIDTH-1:0]     ra_data,
  output logic [WIDTH-1:0]     rb_data,
  output logic [NB*WIDTH-1:0]  b_q,
  input  logic                 sclr_req,
  output logic                 busy,
  output logic                 wr_drop
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [NB-1:0][WIDTH-1:0]    bufs;
  logic [NRD-1:0][AW-1:0]      rd_addr;
  logic [NRD-1:0][WIDTH-1:0]   rd_data;

  sclr_state_t state, nstate;
  logic [AW-1:0] idx;
  logic          sweep_en;
  logic          waddr_hit;
  logic          wr_ok;
  logic          wr_bad;

  // Write address lands on an implemented register (matters for non-pow2 DEPTH)
  always_comb begin
    waddr_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (waddr == AW'(i)) waddr_hit = 1'b1;
    end
  end

  // Accept/discard decision; register 0 in hardwired mode is a silent no-op
  always_comb begin
    wr_bad = we && (busy || !waddr_hit);
`ifdef REGFILE_R0_ZERO_EN
    wr_ok  = we && !busy && waddr_hit && (waddr != '0);
`else
    wr_ok  = we && !busy && waddr_hit;
`endif
  end

  // Soft-clear next state; busy tracks "not heading back to IDLE"
  always_comb begin
    nstate   = state;
    sweep_en = 1'b0;
    case (state)
      IDLE:  if (sclr_req) nstate = SWEEP;
      SWEEP: begin
        sweep_en = 1'b1;
        if (idx == AW'(DEPTH - 1)) nstate = DONE;
      end
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Soft-clear state, sweep index and busy flag
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= nstate;
      busy  <= (nstate != IDLE);
      if (state == SWEEP) idx <= idx + AW'(1);
      else                idx <= '0;
    end
  end

  // Register storage: sweep clear wins, otherwise accepted write
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sweep_en && (idx == AW'(i)))      regs[i] <= '0;
        else if (wr_ok && (waddr == AW'(i))) regs[i] <= s_bus;
      end
`ifdef REGFILE_R0_ZERO_EN
      regs[0] <= '0;
`endif
    end
  end

  // Operand buffers load straight off the S-bus, independent of the sweep
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      bufs <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sb[i]) bufs[i] <= s_bus;
      end
    end
  end

  // One-cycle pulse flagging a discarded write
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) wr_drop <= 1'b0;
    else      wr_drop <= wr_bad;
  end

  assign b_q     = bufs;
  assign rd_addr = {rb_addr, ra_addr};
  assign ra_data = rd_data[0];
  assign rb_data = rd_data[1];

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_rd_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_rd (
      .CLK   (CLK),
      .CLR   (CLR),
      .addr  (rd_addr[p]),
      .regs  (regs),
      .wr_ok (wr_ok),
      .waddr (waddr),
      .s_bus (s_bus),
      .data  (rd_data[p])
    );
  end

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: DEPTH=8 main instance plus DEPTH=6 instance.
module tb_regfile_bank;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        we, sclr_req, busy, wr_drop;
  logic [2:0]  waddr, ra_addr, rb_addr;
  logic [15:0] s_bus, ra_data, rb_data, b_q;
  logic [0:0]  sb;

  logic        we6, busy6, wr_drop6, sclr6;
  logic [2:0]  waddr6, ra6_addr, rb6_addr;
  logic [15:0] ra6_data, rb6_data, b_q6;
  logic [0:0]  sb6;

  int errs   = 0;
  int checks = 0;
  logic [15:0] model [8];
  logic [15:0] v;
  int cnt;

  always #5 CLK = ~CLK;

  regfile_bank #(.WIDTH(16), .DEPTH(8), .NB(1)) dut (
    .CLK(CLK), .CLR(CLR), .we(we), .waddr(waddr), .s_bus(s_bus), .sb(sb),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .b_q(b_q), .sclr_req(sclr_req), .busy(busy), .wr_drop(wr_drop)
  );

  regfile_bank #(.WIDTH(16), .DEPTH(6), .NB(1)) dut6 (
    .CLK(CLK), .CLR(CLR), .we(we6), .waddr(waddr6), .s_bus(s_bus), .sb(sb6),
    .ra_addr(ra6_addr), .rb_addr(rb6_addr), .ra_data(ra6_data), .rb_data(rb6_data),
    .b_q(b_q6), .sclr_req(sclr6), .busy(busy6), .wr_drop(wr_drop6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    CLR = 1'b0; we = 0; waddr = 0; s_bus = 0; sb = 0; ra_addr = 0; rb_addr = 0;
    sclr_req = 0; we6 = 0; waddr6 = 0; ra6_addr = 0; rb6_addr = 0; sclr6 = 0; sb6 = 0;
    tick; tick;
    chk("rst_ra", ra_data, 16'h0);
    chk("rst_rb", rb_data, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", wr_drop, 1'b0);
    chk("rst_bq", b_q, 16'h0);
    chk("rst_ra6", ra6_data, 16'h0);
    CLR = 1'b1;
    tick;

    // Write every register while reading the same address: write-first forward
    for (int i = 0; i < 8; i++) begin
      v = (i == 0) ? 16'hBEEF : (i == 3) ? 16'hA5A5 : 16'(i * 16'h1111);
`ifdef REGFILE_R0_ZERO_EN
      model[i] = (i == 0) ? 16'h0 : v;
`else
      model[i] = v;
`endif
      we = 1; waddr = 3'(i); s_bus = v; ra_addr = 3'(i);
      tick;
      chk($sformatf("fwd%0d", i), ra_data, model[i]);
      chk($sformatf("wdrop%0d", i), wr_drop, 1'b0);
    end
    we = 0;

    // Stored readback on both ports
    for (int i = 0; i < 8; i++) begin
      ra_addr = 3'(i); rb_addr = 3'(7 - i);
      tick;
      chk($sformatf("rda%0d", i), ra_data, model[i]);
      chk($sformatf("rdb%0d", i), rb_data, model[7 - i]);
    end

    // Fill with ones, then soft-clear
    for (int i = 0; i < 8; i++) begin
      we = 1; waddr = 3'(i); s_bus = 16'hFFFF;
      tick;
    end
    we = 0;
    sclr_req = 1;
    tick;
    sclr_req = 0;
    cnt = 0;
    if (busy) cnt++;
    // Write during sweep is dropped and not forwarded; buffer still loads
    we = 1; waddr = 3'd2; s_bus = 16'h1234; sb = 1'b1; ra_addr = 3'd2;
    tick;
    chk("busy_drop", wr_drop, 1'b1);
    chk("buf_sweep", b_q, 16'h1234);
    chk("no_fwd_drop", ra_data, 16'hFFFF);
    we = 0; sb = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      cnt++;
      tick;
    end
    chk("busy_cycles", cnt, 9);
    chk("drop_clear", wr_drop, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ra_addr = 3'(i); rb_addr = 3'(7 - i);
      tick;
      chk($sformatf("swa%0d", i), ra_data, 16'h0);
      chk($sformatf("swb%0d", i), rb_data, 16'h0);
    end
    chk("buf_kept", b_q, 16'h1234);

    // Asynchronous reset in the middle of a sweep
    we = 1; waddr = 3'd5; s_bus = 16'h7777;
    tick;
    we = 0; ra_addr = 3'd5; rb_addr = 3'd5; sclr_req = 1;
    tick;
    sclr_req = 0;
    chk("pre_rst_ra", ra_data, 16'h7777);
    tick; tick;
    chk("mid_busy", busy, 1'b1);
    #3 CLR = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_ra", ra_data, 16'h0);
    chk("arst_rb", rb_data, 16'h0);
    chk("arst_bq", b_q, 16'h0);
    CLR = 1'b1;
    tick;
    chk("post_busy", busy, 1'b0);
    chk("post_ra5", ra_data, 16'h0);

    // DEPTH=6: out-of-range writes are dropped and change nothing
    we6 = 1; waddr6 = 3'd2; s_bus = 16'h2222;
    tick;
    chk("d6_ok", wr_drop6, 1'b0);
    waddr6 = 3'd7; s_bus = 16'hDEAD;
    tick;
    chk("d6_drop7", wr_drop6, 1'b1);
    waddr6 = 3'd6; s_bus = 16'hDEAD;
    tick;
    chk("d6_drop6", wr_drop6, 1'b1);
    we6 = 0; ra6_addr = 3'd2; rb6_addr = 3'd7;
    tick;
    chk("d6_ra2", ra6_data, 16'h2222);
    chk("d6_rb7", rb6_data, 16'h0);
    chk("d6_pulse", wr_drop6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ra6_addr = 3'(i);
      tick;
      chk($sformatf("d6_r%0d", i), ra6_data, (i == 2) ? 16'h2222 : 16'h0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
